// File: rtl/seq_shr.sv
// seq_shr: sequential right shifter that moves one bit per clock.
// A request loads the operand and a saturated shift count. The FSM then
// shifts once per cycle with zero or sign fill and publishes the result on d,
// with a one-cycle done pulse.
module seq_shr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] sh_amt,
  output logic [WIDTH-1:0] d,
  output logic             done,
  output logic             busy
);

  // The counter must be able to hold WIDTH itself, which is the saturated amount.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SAT_AMT = WIDTH[WIDTH-1:0];
  localparam logic [CW-1:0] SAT_CNT = WIDTH[CW-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             arith_reg, arith_next;
  logic             sign_reg, sign_next;
  logic [CW-1:0]    cnt_load;
  logic [WIDTH-1:0] work_shifted;

  // Clamp the requested amount to WIDTH. Anything larger shifts every bit out.
  always_comb begin
    cnt_load = sh_amt[CW-1:0];
    if (sh_amt >= SAT_AMT) begin
      cnt_load = SAT_CNT;
    end
  end

  // Shift by one position. The fill is the latched sign bit only in arithmetic mode.
  always_comb begin
    work_shifted = {arith_reg & sign_reg, work_reg[WIDTH-1:1]};
  end

  // Next-state logic. d is only updated on the transition into DONE.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    arith_next = arith_reg;
    sign_next  = sign_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next  = a;
          arith_next = arith;
          sign_next  = a[WIDTH-1];
          cnt_next   = cnt_load;
          if (cnt_load == '0) begin
            state_next = DONE;
            d_next     = a;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_next = work_shifted;
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = DONE;
          d_next     = work_shifted;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset wins over any request or operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      arith_reg <= 1'b0;
      sign_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      arith_reg <= arith_next;
      sign_reg  <= sign_next;
    end
  end

  assign d    = d_reg;
  assign done = (state_reg == DONE);
  assign busy = (state_reg != IDLE);

endmodule
